// File: rtl/nand5_tester.sv
// Exhaustive stimulus generator and response checker for a WIDTH-input NAND gate.
// Walks every input vector, lets it settle, samples the gate output and tallies mismatches.
module nand5_tester #(
  parameter int unsigned WIDTH         = 5,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dut_y,
  output logic [WIDTH-1:0] stim,
  output logic             vec_strobe,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_count,
  output logic             first_fail_valid,
  output logic [WIDTH-1:0] first_fail_vec
);

  if (SETTLE_CYCLES == 0) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] stim_q, stim_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   err_q, err_d;
  logic             ffv_q, ffv_d;
  logic [WIDTH-1:0] ffvec_q, ffvec_d;

  logic launch;
  logic stim_last;
  logic expected_y;
  logic mismatch;

  // start is only honoured when no run is in flight
  assign launch     = ((state_q == StIdle) || (state_q == StDone)) && start;
  assign stim_last  = &stim_q;
  assign expected_y = ~(&stim_q);
  assign mismatch   = (dut_y != expected_y);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == CntLast) state_d = StSample;
      end
      StSample: begin
        state_d = stim_last ? StDone : StSettle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: stimulus walk, settle timing and result capture
  always_comb begin
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    if (launch) begin
      stim_d  = '0;
      cnt_d   = '0;
      err_d   = '0;
      ffv_d   = 1'b0;
      ffvec_d = '0;
    end else if (state_q == StSettle) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    end else if (state_q == StSample) begin
      cnt_d = '0;
      if (mismatch) begin
        err_d = err_q + 1'b1;
        if (!ffv_q) begin
          ffv_d   = 1'b1;
          ffvec_d = stim_q;
        end
      end
      // The final vector stays on the pins so DONE reflects what was last applied
      if (!stim_last) stim_d = stim_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else begin
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end

  // Outputs depend only on registered state, never on dut_y or start directly
  always_comb begin
    vec_strobe       = (state_q == StSample);
    busy             = (state_q == StSettle) || (state_q == StSample);
    done             = (state_q == StDone);
    pass             = (state_q == StDone) && (err_q == '0);
    stim             = stim_q;
    err_count        = err_q;
    first_fail_valid = ffv_q;
    first_fail_vec   = ffvec_q;
  end

endmodule

// File: tb/tb_nand5_tester.sv
// Scoreboard bench for nand5_tester: behavioural NAND variants drive dut_y, a negedge
// monitor checks every strobe and every run result against queued expectations.
module tb_nand5_tester;

  localparam int unsigned W  = 5;
  localparam int unsigned S  = 4;
  localparam int unsigned P  = S + 1;
  localparam int unsigned NV = 32;

  typedef struct {
    int unsigned cyc;
    logic [W-1:0] vec;
  } strobe_t;

  typedef struct {
    int unsigned cyc;
    logic [W:0]   err;
    logic         pass;
    logic         ffv;
    logic [W-1:0] ffvec;
  } result_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start;
  logic         dut_y;
  logic [W-1:0] stim;
  logic         vec_strobe, busy, done, pass;
  logic [W:0]   err_count;
  logic         first_fail_valid;
  logic [W-1:0] first_fail_vec;

  logic         start2;
  logic         dut_y2;
  logic [W-1:0] stim2;
  logic         vec_strobe2, busy2, done2, pass2;
  logic [W:0]   err_count2;
  logic         first_fail_valid2;
  logic [W-1:0] first_fail_vec2;

  int unsigned mode;
  logic        y_d1, y_d2, z_d1, z_d2;

  strobe_t     sq[$];
  result_t     rq[$];
  int          checks;
  int          errors;
  int unsigned cyc;
  logic        count_restart;
  logic        done_prev;
  logic        mon_en;

  nand5_tester #(.WIDTH(W), .SETTLE_CYCLES(S)) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .dut_y            (dut_y),
    .stim             (stim),
    .vec_strobe       (vec_strobe),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_vec   (first_fail_vec)
  );

  nand5_tester #(.WIDTH(W), .SETTLE_CYCLES(1)) u_dut_s1 (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start2),
    .dut_y            (dut_y2),
    .stim             (stim2),
    .vec_strobe       (vec_strobe2),
    .busy             (busy2),
    .done             (done2),
    .pass             (pass2),
    .err_count        (err_count2),
    .first_fail_valid (first_fail_valid2),
    .first_fail_vec   (first_fail_vec2)
  );

  // Two-cycle propagation gate models
  always @(posedge clk) begin
    y_d1 <= ~(&stim);
    y_d2 <= y_d1;
    z_d1 <= ~(&stim2);
    z_d2 <= z_d1;
  end
  assign dut_y2 = z_d2;

  always_comb begin
    case (mode)
      0:       dut_y = ~(&stim);
      1:       dut_y = 1'b1;
      2:       dut_y = 1'b0;
      3:       dut_y = ~(&stim[3:0]);
      default: dut_y = y_d2;
    endcase
  end

  // cyc at a negedge is the cycle number of the interval in progress (start edge = cycle 0)
  always @(posedge clk) begin
    if (start && count_restart) cyc <= 1;
    else                        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  always @(negedge clk) begin
    strobe_t es;
    result_t er;
    if (rst_n && mon_en) begin
      if (vec_strobe) begin
        if (sq.size() == 0) fail_now("strobe_unexpected");
        else begin
          es = sq.pop_front();
          check("strobe_vec", 32'(stim), 32'(es.vec));
          check("strobe_cycle", cyc, es.cyc);
        end
      end
      if (done && !done_prev) begin
        if (rq.size() == 0) fail_now("done_unexpected");
        else begin
          er = rq.pop_front();
          check("done_cycle", cyc, er.cyc);
          check("err_count", 32'(err_count), 32'(er.err));
          check("pass", 32'(pass), 32'(er.pass));
          check("first_fail_valid", 32'(first_fail_valid), 32'(er.ffv));
          check("first_fail_vec", 32'(first_fail_vec), 32'(er.ffvec));
          check("done_busy", 32'(busy), 0);
        end
      end
    end
    done_prev <= done;
  end

  task automatic run(input int unsigned m, input logic [W:0] exp_err, input logic exp_ffv,
                     input logic [W-1:0] exp_ffvec, input bit repulse);
    strobe_t es;
    result_t er;
    int n;
    mode = m;
    for (int k = 0; k < NV; k++) begin
      es.cyc = (k + 1) * P;
      es.vec = W'(k);
      sq.push_back(es);
    end
    er.cyc   = NV * P + 1;
    er.err   = exp_err;
    er.pass  = (exp_err == 0);
    er.ffv   = exp_ffv;
    er.ffvec = exp_ffvec;
    rq.push_back(er);
    start = 1'b1;
    count_restart = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    count_restart = 1'b0;
    check("launch_busy", 32'(busy), 1);
    check("launch_done", 32'(done), 0);
    check("launch_err_cleared", 32'(err_count), 0);
    check("launch_ffv_cleared", 32'(first_fail_valid), 0);
    check("launch_stim", 32'(stim), 0);
    if (repulse) begin
      n = 0;
      while (cyc < 40 && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) fail_now("done_timeout");
    @(posedge clk);
    #1;
    check("done_stim_held", 32'(stim), 31);
    check("strobe_queue_empty", sq.size(), 0);
    check("result_queue_empty", rq.size(), 0);
    sq.delete();
    rq.delete();
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    mode = 0;
    count_restart = 1'b0;
    cyc = 0;
    done_prev = 1'b0;
    mon_en = 1'b1;
    #2;
    check("rst_stim", 32'(stim), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_err", 32'(err_count), 0);
    check("rst_ffv", 32'(first_fail_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 0);
    check("idle_strobe", 32'(vec_strobe), 0);

    run(0, 0, 1'b0, 5'd0, 1'b0);
    run(1, 1, 1'b1, 5'd31, 1'b0);
    run(1, 1, 1'b1, 5'd31, 1'b0);
    run(2, 31, 1'b1, 5'd0, 1'b0);
    run(3, 1, 1'b1, 5'd15, 1'b0);
    run(4, 0, 1'b0, 5'd0, 1'b0);
    run(0, 0, 1'b0, 5'd0, 1'b1);

    // Asynchronous reset in the middle of a run
    mon_en = 1'b0;
    mode = 0;
    start = 1'b1;
    count_restart = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    count_restart = 1'b0;
    n = 0;
    while (cyc < 50 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("pre_reset_busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_stim", 32'(stim), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_strobe", 32'(vec_strobe), 0);
    check("async_rst_err", 32'(err_count), 0);
    check("async_rst_ffvec", 32'(first_fail_vec), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Slow gate with too short a settle time
    mode = 0;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done2) fail_now("s1_done_timeout");
    check("s1_err_nonzero", 32'(err_count2 != 0), 1);
    check("s1_pass", 32'(pass2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

endmodule
